// File: rtl/anc_i2s_tx.sv
// I2S transmitter (slave timing): serializes one stereo pair per LRC frame on BCLK falling
// edges, with single-entry buffering of the next pair and underrun/overrun pulses.
module anc_i2s_tx #(
  parameter int AUDIO_WIDTH = 16,
  parameter int SLOT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AUDIO_WIDTH-1:0] audio_yn1_i,
  input  logic [AUDIO_WIDTH-1:0] audio_yn2_i,
  input  logic                   audio_tx_load,
  input  logic                   i2s_bclk,
  input  logic                   i2s_lrclk,
  output logic                   i2s_dacdat,
  output logic                   audio_tx_req,
  output logic                   tx_underrun,
  output logic                   tx_overrun,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(SLOT_WIDTH + 1);
  localparam int PAD_W = SLOT_WIDTH - AUDIO_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_WIDTH);

  state_t                 state, state_nxt;
  logic                   bclk_s1, bclk_s2, bclk_d;
  logic                   lrc_s1, lrc_s2, lrc_prev;
  logic                   bclk_fall, lrc_edge, left_start, right_start, slot_start;
  logic [SLOT_WIDTH-1:0]  sr, slot_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic [AUDIO_WIDTH-1:0] hold_l, hold_r, active_l, active_r, next_l, next_r;
  logic                   pending;

  assign bclk_fall   = bclk_d & ~bclk_s2;
  assign lrc_edge    = bclk_fall & (lrc_s2 != lrc_prev);
  assign left_start  = lrc_edge & ~lrc_s2;
  assign right_start = lrc_edge & lrc_s2 & (state != IDLE);
  assign slot_start  = left_start | right_start;
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (left_start) state_nxt = LEFT;
      LEFT, RIGHT: begin
        if (left_start)       state_nxt = LEFT;
        else if (right_start) state_nxt = RIGHT;
      end
      default:     state_nxt = IDLE;
    endcase
  end

  // Load/request handshake: audio_tx_load is a single-clk write into a one-deep buffer
  // (no ready); audio_tx_req pulses at every left slot start when that buffer is consumed.
  // A load coincident with the left start bypasses the buffer into this frame.
  always_comb begin
    next_l = active_l;
    next_r = active_r;
    if (left_start) begin
      if (audio_tx_load) begin
        next_l = audio_yn1_i;
        next_r = audio_yn2_i;
      end else if (pending) begin
        next_l = hold_l;
        next_r = hold_r;
      end
    end
    slot_word = left_start ? {next_l, {PAD_W{1'b0}}} : {active_r, {PAD_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bclk_s1      <= 1'b0;
      bclk_s2      <= 1'b0;
      bclk_d       <= 1'b0;
      lrc_s1       <= 1'b0;
      lrc_s2       <= 1'b0;
      lrc_prev     <= 1'b0;
      sr           <= '0;
      bit_cnt      <= '0;
      hold_l       <= '0;
      hold_r       <= '0;
      active_l     <= '0;
      active_r     <= '0;
      pending      <= 1'b0;
      i2s_dacdat   <= 1'b0;
      audio_tx_req <= 1'b0;
      tx_underrun  <= 1'b0;
      tx_overrun   <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;
      bclk_s2 <= bclk_s1;
      bclk_d  <= bclk_s2;
      lrc_s1  <= i2s_lrclk;
      lrc_s2  <= lrc_s1;
      if (bclk_fall) lrc_prev <= lrc_s2;

      state <= state_nxt;

      audio_tx_req <= left_start;
      tx_underrun  <= left_start & ~audio_tx_load & ~pending;
      tx_overrun   <= audio_tx_load & pending & ~left_start;

      if (left_start)         pending <= 1'b0;
      else if (audio_tx_load) pending <= 1'b1;
      if (audio_tx_load && !left_start) begin
        hold_l <= audio_yn1_i;
        hold_r <= audio_yn2_i;
      end
      active_l <= next_l;
      active_r <= next_r;

      // The slot-start edge only loads; the first bit leaves one BCLK later (I2S delay).
      if (slot_start) begin
        sr      <= slot_word;
        bit_cnt <= '0;
      end else if (bclk_fall && state != IDLE) begin
        sr <= {sr[SLOT_WIDTH-2:0], 1'b0};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (state == IDLE) begin
        i2s_dacdat <= 1'b0;
      end else if (bclk_fall && !slot_start) begin
        i2s_dacdat <= (bit_cnt < CNT_MAX) ? sr[SLOT_WIDTH-1] : 1'b0;
      end
    end
  end

endmodule

// File: doc/anc_i2s_tx.md
ANC_I2S_TX -- requirements
Module: anc_i2s_tx

Interface
REQ-001 Parameter AUDIO_WIDTH, default 16, the sample width in bits for each channel.
REQ-002 Parameter SLOT_WIDTH, default 32, the number of BCLK periods per channel slot; SLOT_WIDTH SHALL be at least AUDIO_WIDTH+1.
REQ-003 clk  in  1  system clock; the block has one clock; clk frequency SHALL be at least 8x the BCLK frequency.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 audio_yn1_i  in  AUDIO_WIDTH  signed left-channel sample (fn).
REQ-006 audio_yn2_i  in  AUDIO_WIDTH  signed right-channel sample (yn).
REQ-007 audio_tx_load  in  1  one-clk strobe; latches audio_yn1_i and audio_yn2_i as one stereo pair.
REQ-008 i2s_bclk  in  1  codec bit clock; asynchronous to clk.
REQ-009 i2s_lrclk  in  1  codec word clock; asynchronous to clk; 0 = left, 1 = right.
REQ-010 i2s_dacdat  out  1  serial data to the codec DAC.
REQ-011 audio_tx_req  out  1  one-clk pulse at each left-slot start; requests the next pair.
REQ-012 tx_underrun  out  1  one-clk pulse: a left slot started with no new pair pending.
REQ-013 tx_overrun  out  1  one-clk pulse: audio_tx_load arrived while a pair was already pending.

Function
REQ-014 i2s_bclk and i2s_lrclk SHALL each pass through a 2-flop synchronizer in the clk domain; bclk_fall is asserted for one clk when synchronized BCLK goes from 1 to 0; lrc_prev holds synchronized LRC sampled at the previous bclk_fall.
REQ-015 All serial activity SHALL occur only on cycles where bclk_fall is asserted.
REQ-016 State machine states: IDLE, LEFT, RIGHT.
REQ-017 IDLE: i2s_dacdat = 0; go to LEFT on the first bclk_fall where LRC = 0 and lrc_prev = 1; any other LRC level or edge stays in IDLE.
REQ-018 In LEFT or RIGHT, a bclk_fall with LRC != lrc_prev SHALL mark a slot start and move the FSM to LEFT (LRC = 0) or RIGHT (LRC = 1).
REQ-019 Slot start: the shift register loads active_l in LEFT or active_r in RIGHT, left-aligned in SLOT_WIDTH bits with zero fill; bit_cnt clears; i2s_dacdat is not updated on this edge (I2S one-bit delay).
REQ-020 Each subsequent bclk_fall in the same slot: i2s_dacdat takes the shift-register MSB; the shift register shifts left with zero fill; bit_cnt increments and saturates at SLOT_WIDTH.
REQ-021 Result: the sample MSB is driven on the second BCLK falling edge after the LRC transition, then AUDIO_WIDTH-1 further bits MSB-first, then zeros until the next slot start.
REQ-022 A slot longer than SLOT_WIDTH BCLKs SHALL output zeros; a slot that ends early SHALL be truncated without error.
REQ-023 audio_tx_load SHALL write hold_l and hold_r and set pending; if pending was already set, the hold registers are overwritten and tx_overrun pulses.
REQ-024 Left slot start with pending set: active_l/active_r <= hold_l/hold_r; pending clears; audio_tx_req pulses.
REQ-025 Left slot start with pending clear: active_l/active_r keep their previous values (last pair repeated); tx_underrun and audio_tx_req pulse.
REQ-026 audio_tx_load in the same clk as a left slot start: the new inputs go directly to active_l/active_r and are serialized in this frame; pending ends clear; no underrun and no overrun.
REQ-027 Right slot start SHALL use active_r captured at the preceding left slot start, so L/R stay coherent; a load during a frame does not affect that frame.
REQ-028 The transition out of IDLE SHALL count as a left slot start and is subject to REQ-024 to REQ-026.

Reset
REQ-029 While rst_n = 0 at a clk edge: the FSM goes to IDLE; synchronizers, lrc_prev, shift register, bit_cnt, hold and active registers and pending clear to 0; i2s_dacdat, audio_tx_req, tx_underrun and tx_overrun are 0.
REQ-030 Reset asserted mid-slot SHALL abort serialization immediately; after release, output resumes only at the next LRC 1->0 edge per REQ-017.

Verification
REQ-031 Load L=16'hA5C3, R=16'h0F0F; run BCLK=clk/16 with 32-bit slots -> left slot bits 1..16 = A5C3 MSB-first, right = 0F0F, remaining bits 0, one audio_tx_req pulse.
REQ-032 No load before the second frame -> tx_underrun pulses; A5C3/0F0F are repeated.
REQ-033 Two loads in one frame (1111/2222, then 3333/4444) -> tx_overrun pulses once; the next frame sends 3333/4444.
REQ-034 Load coincident with the left-start clk (7FFF/8000) -> the same frame sends 7FFF/8000; no underrun and no overrun.
REQ-035 Start the bench with LRC=1 mid-slot -> i2s_dacdat stays 0 until the first LRC falling edge; then the normal frame follows.
REQ-036 Assert rst_n=0 for 1 clk in the middle of the left slot -> outputs are 0 at once; the FSM returns to IDLE; serialization resumes correctly at the next left start.
